// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_arb slice: FSM states, requester ids, bus widths.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package mem_arb_pkg;
   localparam int unsigned AW = `ADDR_WIDTH;
   localparam int unsigned DW = `DATA_WIDTH;
   localparam int unsigned MW = DW / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;
endpackage

// File: rtl/arb_pick2.sv
// Two-way grant picker; prio_lsu selects who wins when both request.
module arb_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio_lsu,
   output logic [1:0] gnt
);
   always_comb begin
      gnt = '0;
      if (req[OWN_LSU] && (prio_lsu || !req[OWN_IFU])) gnt[OWN_LSU] = 1'b1;
      else if (req[OWN_IFU])                           gnt[OWN_IFU] = 1'b1;
   end
endmodule

// File: rtl/mem_arb.sv
// Fetch/load-store arbiter onto a single-outstanding RAM port with read timeout.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests (default: LSU wins).
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int unsigned RSP_TIMEOUT = 255
) (
   input  logic          i_sys_clk,
   input  logic          i_sys_rst,
   input  logic          i_ifu_req_valid,
   output logic          o_ifu_req_ready,
   input  logic [AW-1:0] i_ifu_req_addr,
   output logic          o_ifu_rsp_valid,
   output logic [DW-1:0] o_ifu_rsp_data,
   input  logic          i_lsu_req_valid,
   output logic          o_lsu_req_ready,
   input  logic          i_lsu_req_wr_en,
   input  logic [AW-1:0] i_lsu_req_addr,
   input  logic [DW-1:0] i_lsu_req_wr_data,
   input  logic [MW-1:0] i_lsu_req_wr_mask,
   output logic          o_lsu_rsp_valid,
   output logic [DW-1:0] o_lsu_rsp_data,
   output logic          o_ram_req_valid,
   input  logic          i_ram_req_ready,
   output logic          o_ram_req_wr_en,
   output logic [AW-1:0] o_ram_req_addr,
   output logic [DW-1:0] o_ram_req_wr_data,
   output logic [MW-1:0] o_ram_req_wr_mask,
   input  logic          i_ram_rsp_valid,
   input  logic [DW-1:0] i_ram_rsp_data,
   output logic          o_arb_err
);
   state_t        state;
   owner_t        owner;
   logic [15:0]   rsp_cnt;
   logic [1:0]    req;
   logic [1:0]    gnt;
   logic          prio_lsu;
   logic          timeout;
   logic [DW-1:0] rsp_word;

   assign req = {i_lsu_req_valid, i_ifu_req_valid} & {2{state == ST_IDLE}};

`ifdef MEM_ARB_RR_EN
   logic rr_lsu;

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst)  rr_lsu <= 1'b1;
      else if (|gnt)  rr_lsu <= gnt[OWN_IFU];
   end

   assign prio_lsu = rr_lsu;
`else
   assign prio_lsu = 1'b1;
`endif

   arb_pick2 u_pick (
      .req      (req),
      .prio_lsu (prio_lsu),
      .gnt      (gnt)
   );

   // Readies are gated by reset so every output is low while reset is held.
   assign o_ifu_req_ready = gnt[OWN_IFU] & ~i_sys_rst;
   assign o_lsu_req_ready = gnt[OWN_LSU] & ~i_sys_rst;
   assign o_ram_req_valid = (state == ST_REQ);

   // rsp_cnt holds k-1 in the k-th RSP cycle; abort fires at the end of cycle RSP_TIMEOUT.
   assign timeout  = (rsp_cnt == 16'(RSP_TIMEOUT - 1));
   assign rsp_word = i_ram_rsp_valid ? i_ram_rsp_data : '0;

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state             <= ST_IDLE;
         owner             <= OWN_LSU;
         rsp_cnt           <= '0;
         o_ram_req_wr_en   <= 1'b0;
         o_ram_req_addr    <= '0;
         o_ram_req_wr_data <= '0;
         o_ram_req_wr_mask <= '0;
         o_ifu_rsp_valid   <= 1'b0;
         o_ifu_rsp_data    <= '0;
         o_lsu_rsp_valid   <= 1'b0;
         o_lsu_rsp_data    <= '0;
         o_arb_err         <= 1'b0;
      end else begin
         o_ifu_rsp_valid <= 1'b0;
         o_lsu_rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt[OWN_LSU]) begin
                  state             <= ST_REQ;
                  owner             <= OWN_LSU;
                  o_ram_req_wr_en   <= i_lsu_req_wr_en;
                  o_ram_req_addr    <= i_lsu_req_addr;
                  o_ram_req_wr_data <= i_lsu_req_wr_data;
                  o_ram_req_wr_mask <= i_lsu_req_wr_mask;
               end else if (gnt[OWN_IFU]) begin
                  state             <= ST_REQ;
                  owner             <= OWN_IFU;
                  o_ram_req_wr_en   <= 1'b0;
                  o_ram_req_addr    <= i_ifu_req_addr;
                  o_ram_req_wr_data <= '0;
                  o_ram_req_wr_mask <= '0;
               end
            end
            ST_REQ: begin
               if (i_ram_req_ready) begin
                  rsp_cnt <= '0;
                  if (o_ram_req_wr_en) begin
                     state           <= ST_IDLE;
                     o_lsu_rsp_valid <= 1'b1;
                     o_lsu_rsp_data  <= '0;
                  end else begin
                     state <= ST_RSP;
                  end
               end
            end
            ST_RSP: begin
               rsp_cnt <= rsp_cnt + 16'd1;
               if (i_ram_rsp_valid || timeout) begin
                  state <= ST_IDLE;
                  if (!i_ram_rsp_valid) o_arb_err <= 1'b1;
                  if (owner == OWN_LSU) begin
                     o_lsu_rsp_valid <= 1'b1;
                     o_lsu_rsp_data  <= rsp_word;
                  end else begin
                     o_ifu_rsp_valid <= 1'b1;
                     o_ifu_rsp_data  <= rsp_word;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter RSP_TIMEOUT, default 255: cycles waited for a read response before abort; legal range 1..65535.
REQ-002 Address and data widths SHALL be the codebase globals `ADDR_WIDTH` (32) and `DATA_WIDTH` (64); the mask is `DATA_WIDTH`/8 bits.
REQ-003 i_sys_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_sys_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_ifu_req_valid  in  1  fetch read request.
REQ-006 o_ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-007 i_ifu_req_addr  in  ADDR  fetch address.
REQ-008 o_ifu_rsp_valid  out  1  one-cycle fetch data pulse.
REQ-009 o_ifu_rsp_data  out  DATA  fetch data.
REQ-010 i_lsu_req_valid  in  1  load/store request.
REQ-011 o_lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-012 i_lsu_req_wr_en  in  1  1 = store, 0 = load.
REQ-013 i_lsu_req_addr  in  ADDR  load/store address.
REQ-014 i_lsu_req_wr_data  in  DATA  store data.
REQ-015 i_lsu_req_wr_mask  in  DATA/8  store byte mask.
REQ-016 o_lsu_rsp_valid  out  1  one-cycle load data or store done pulse.
REQ-017 o_lsu_rsp_data  out  DATA  load data; zero for stores.
REQ-018 o_ram_req_valid  out  1  RAM request.
REQ-019 i_ram_req_ready  in  1  RAM accepts request.
REQ-020 o_ram_req_wr_en, o_ram_req_addr, o_ram_req_wr_data, o_ram_req_wr_mask  out  1/ADDR/DATA/DATA/8  registered copy of the granted request.
REQ-021 i_ram_rsp_valid  in  1  read data valid.
REQ-022 i_ram_rsp_data  in  DATA  read data.
REQ-023 o_arb_err  out  1  sticky read-timeout flag.

Function
REQ-024 FSM states SHALL be IDLE, REQ and RSP.
REQ-025 In IDLE, the block SHALL grant exactly one valid requester combinationally: only that requester's req_ready is high, its fields are latched, and the owner is recorded.
- Transition: IDLE -> REQ.
- No valid requester: stay in IDLE; both readies low.
REQ-026 In REQ, o_ram_req_valid SHALL be 1 with the latched fields, held stable until i_ram_req_ready.
- Accepted read: -> RSP.
- Accepted store: -> IDLE, with o_lsu_rsp_valid pulsed the cycle after acceptance.
REQ-027 In RSP, on i_ram_rsp_valid the data SHALL be forwarded to the owner's rsp_data with a one-cycle rsp_valid pulse in the following cycle; -> IDLE.
REQ-028 Minimum latency: accept at T, RAM request at T+1, and, for a 1-cycle RAM, response to the requester at T+3.
REQ-029 Readies SHALL be 0 in REQ and RSP; at most one request is outstanding at any time.
REQ-030 In RSP, a 16-bit counter SHALL count cycles; on reaching RSP_TIMEOUT, the block SHALL set o_arb_err, pulse the owner's rsp_valid with zero data, and go to IDLE.
REQ-031 i_ram_rsp_valid outside RSP SHALL be ignored, including late responses after a timeout.
REQ-032 rsp_data SHALL hold its value between pulses; the non-owner's rsp_valid SHALL never pulse.

Reset
REQ-033 Asserting i_sys_rst at any time, including mid-transaction, SHALL immediately force:
- FSM to IDLE, counter to 0;
- all outputs to 0, including o_arb_err;
- the priority pointer to LSU-first.
REQ-034 An in-flight transaction SHALL be dropped silently, with no response pulse.

Configuration
REQ-035 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not granted most recently wins, with LSU first after reset.
REQ-036 Without MEM_ARB_RR_EN, LSU SHALL always win simultaneous requests, and the pointer register SHALL be absent.

Structure
REQ-037 The state enum (IDLE/REQ/RSP) and the owner enum (IFU/LSU) SHALL live in shared package mem_arb_pkg.
REQ-038 The grant decision SHALL be a sub-module arb_pick2, with requests and pointer in and a one-hot grant out, instantiated once.

Verification
REQ-039 IFU-only read: addr 0x80000000, RAM returns 0x1122334455667788 one cycle after acceptance -> o_ifu_rsp_valid pulse at T+3 with that data; LSU rsp stays 0.
REQ-040 LSU store: addr 0x80001000, data 0xAB, mask 0x01, i_ram_req_ready delayed 3 cycles -> RAM fields stable for 4 cycles; o_lsu_rsp_valid pulse with data 0.
REQ-041 Both requesters valid continuously for 4 transactions -> RR_EN grants LSU, IFU, LSU, IFU; without RR_EN grants LSU four times.
REQ-042 RSP_TIMEOUT=4, no i_ram_rsp_valid -> owner rsp pulse with 0 in the 4th RSP cycle, o_arb_err=1, next request is still served.
REQ-043 i_sys_rst asserted in RSP -> outputs 0 in the same cycle; a later stray i_ram_rsp_valid produces no pulse.
